cmp_multi: RTL and testbench

Parametrised multi-match hash comparator, next generation of the single-match linear comparator in the bcrypt result path. Holds up to `NUM_HASHES` target hashes of `CMP_WIDTH` bits, loaded bytewise from cmp_config, and linearly scans them against one computed hash per `start`. Unlike the previous block, it can report every matching entry through a valid/ready handshake instead of stopping at the first. It also supports abort and a stop-on-first mode.

---
 rtl/cmp_multi.sv | 124 ++++++++++++
 tb/tb_cmp_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_multi.sv
// cmp_multi: multi-match linear hash comparator with valid/ready match reporting
module cmp_multi #(
    parameter int NUM_HASHES    = 512,
    parameter int CMP_WIDTH     = 32,
    parameter bit STOP_ON_FIRST = 1'b0,
    localparam int IW    = $clog2(NUM_HASHES),
    localparam int CW    = IW + 1,
    localparam int BYTES = CMP_WIDTH / 8,
    localparam int AW    = IW + $clog2(BYTES)
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [7:0]           din,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CW-1:0]        hash_count,
    input  logic [CMP_WIDTH-1:0] cmp_data,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 match_valid,
    input  logic                 match_ready,
    output logic [IW-1:0]        match_num,
    output logic                 found,
    output logic                 finished
);
    typedef enum logic [2:0] {IDLE, START, START2, COMPARE, HOLD} state_t;
    state_t               state_q, state_d;
    logic [IW-1:0]        rd_addr_q, rd_addr_d, idx_q, idx_d, match_num_q, match_num_d;
    logic [CMP_WIDTH-1:0] cmp_q, cmp_d, ram_q, dout_q;
    logic [CW-1:0]        n_eff_q, n_eff_d, n_eff_in;
    logic                 match_valid_q, match_valid_d, found_q, found_d, finished_q, finished_d;
    logic                 rd_en, last;
    logic [CMP_WIDTH-1:0] mem [NUM_HASHES];
    assign rd_en    = state_q inside {START, START2, COMPARE};
    assign last     = CW'(idx_q) == n_eff_q - CW'(1);
    assign n_eff_in = hash_count > CW'(NUM_HASHES) ? CW'(NUM_HASHES) : hash_count;
    // Synchronous read plus an explicit output register, both gated by rd_en so HOLD freezes them.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < BYTES; k++)
            if (wr_en && wr_addr % AW'(BYTES) == AW'(k)) mem[wr_addr[AW-1 -: IW]][8*k +: 8] <= din;
        if (rd_en) begin
            ram_q  <= mem[rd_addr_q];
            dout_q <= ram_q;
        end
    end
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_en ? rd_addr_q + IW'(1) : rd_addr_q;
        idx_d         = idx_q;
        cmp_d         = cmp_q;
        n_eff_d       = n_eff_q;
        match_valid_d = match_valid_q;
        match_num_d   = match_num_q;
        found_d       = found_q;
        finished_d    = finished_q;
        if (abort) begin
            state_d       = IDLE;
            match_valid_d = 1'b0;
            found_d       = 1'b0;
            finished_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cmp_d      = cmp_data;
                    n_eff_d    = n_eff_in;
                    rd_addr_d  = '0;
                    idx_d      = '0;
                    found_d    = 1'b0;
                    finished_d = n_eff_in == '0;
                    state_d    = n_eff_in == '0 ? IDLE : START;
                end
                START:  state_d = START2;
                START2: state_d = COMPARE;
                COMPARE: if (dout_q == cmp_q) begin
                    match_valid_d = 1'b1;
                    match_num_d   = idx_q;
                    found_d       = 1'b1;
                    state_d       = HOLD;
                end else if (last) begin
                    finished_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                HOLD: if (match_valid_q && match_ready) begin
                    match_valid_d = 1'b0;
                    finished_d    = STOP_ON_FIRST || last;
                    state_d       = STOP_ON_FIRST || last ? IDLE : COMPARE;
                    idx_d         = STOP_ON_FIRST || last ? idx_q : idx_q + IW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            idx_q         <= '0;
            cmp_q         <= '0;
            n_eff_q       <= '0;
            match_valid_q <= 1'b0;
            match_num_q   <= '0;
            found_q       <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            idx_q         <= idx_d;
            cmp_q         <= cmp_d;
            n_eff_q       <= n_eff_d;
            match_valid_q <= match_valid_d;
            match_num_q   <= match_num_d;
            found_q       <= found_d;
            finished_q    <= finished_d;
        end
    end
    assign busy        = state_q != IDLE;
    assign match_valid = match_valid_q;
    assign match_num   = match_num_q;
    assign found       = found_q;
    assign finished    = finished_q;
endmodule

// File: tb/tb_cmp_multi.sv
// tb_cmp_multi: scoreboard bench for cmp_multi; dut0 reports every match, dut1 stops on the first.
module tb_cmp_multi;
    localparam int NH = 512;
    logic        CLK = 1'b0, rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [9:0]  hash_count = '0;
    logic [31:0] cmp_data = '0;
    logic        start = 1'b0, abort = 1'b0, match_ready = 1'b0;
    logic        busy0, mv0, found0, fin0, busy1, mv1, found1, fin1;
    logic [8:0]  num0, num1;
    logic        use_sof = 1'b0;
    logic        o_busy, o_mv, o_found, o_fin;
    logic [8:0]  o_num;
    logic [31:0] model [NH];
    int          exp_q [$];
    int          checks = 0, errors = 0;

    assign o_busy  = use_sof ? busy1 : busy0;
    assign o_mv    = use_sof ? mv1 : mv0;
    assign o_found = use_sof ? found1 : found0;
    assign o_fin   = use_sof ? fin1 : fin0;
    assign o_num   = use_sof ? num1 : num0;

    always #5 CLK = ~CLK;

    cmp_multi #(.NUM_HASHES(NH), .CMP_WIDTH(32), .STOP_ON_FIRST(1'b0)) dut0 (
        .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_addr(wr_addr),
        .hash_count(hash_count), .cmp_data(cmp_data), .start(start), .abort(abort),
        .busy(busy0), .match_valid(mv0), .match_ready(match_ready), .match_num(num0),
        .found(found0), .finished(fin0));

    cmp_multi #(.NUM_HASHES(NH), .CMP_WIDTH(32), .STOP_ON_FIRST(1'b1)) dut1 (
        .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_addr(wr_addr),
        .hash_count(hash_count), .cmp_data(cmp_data), .start(start), .abort(abort),
        .busy(busy1), .match_valid(mv1), .match_ready(match_ready), .match_num(num1),
        .found(found1), .finished(fin1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int n, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            wr_en   = 1'b1;
            wr_addr = 11'(n * 4 + k);
            din     = v[8*k +: 8];
            @(negedge CLK);
        end
        wr_en    = 1'b0;
        model[n] = v;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy0 || busy1); i++) @(negedge CLK);
        check("idle", 32'({busy0, busy1}), 32'd0);
    endtask

    // fin_k: edges after the start edge at which finished was first seen high (-1 on timeout)
    task automatic scan(input int cnt, input logic [31:0] d, input int stall, input logic sof,
                        output int fin_k);
        int n, held, k, nexp;
        n = cnt > NH ? NH : cnt;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            if (model[i] == d && !(sof && exp_q.size() > 0)) exp_q.push_back(i);
        nexp        = exp_q.size();
        use_sof     = sof;
        match_ready = (stall == 0);
        hash_count  = 10'(cnt);
        cmp_data    = d;
        start       = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        held  = 0;
        fin_k = -1;
        k     = 0;
        while (fin_k < 0 && k < 2000) begin
            check("fin_busy", 32'(o_fin & o_busy), 32'd0);
            check("fin_mv", 32'(o_fin & o_mv), 32'd0);
            if (o_fin) fin_k = k;
            else begin
                if (o_mv && !match_ready) begin
                    check("hold_num", 32'(o_num), exp_q.size() > 0 ? exp_q[0] : 32'hffff_ffff);
                    held++;
                    if (held >= stall) match_ready = 1'b1;
                end
                if (o_mv && match_ready) begin
                    check("match_num", 32'(o_num), exp_q.size() > 0 ? exp_q[0] : 32'hffff_ffff);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                @(negedge CLK);
                k++;
            end
        end
        check("finished", 32'(o_fin), 32'd1);
        check("busy_end", 32'(o_busy), 32'd0);
        check("unreported", 32'(exp_q.size()), 32'd0);
        check("found", 32'(o_found), 32'(nexp > 0));
        match_ready = 1'b1;
    endtask

    initial begin
        int fk;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_mv", 32'(mv0), 32'd0);
        check("rst_num", 32'(num0), 32'd0);
        check("rst_found", 32'(found0), 32'd0);
        check("rst_fin", 32'(fin0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) write_entry(i, 32'(i));
        scan(8, 32'hDEAD_BEEF, 0, 1'b0, fk);
        check("nomatch_fin_k", 32'(fk), 32'd10);
        wait_idle();
        write_entry(2, 32'hCAFE_F00D);
        write_entry(5, 32'hCAFE_F00D);
        scan(8, 32'hCAFE_F00D, 0, 1'b0, fk);
        check("multi_fin_k", 32'(fk), 32'd12);
        wait_idle();
        scan(8, 32'hCAFE_F00D, 10, 1'b0, fk);
        check("stall_fin_k", 32'(fk), 32'd21);
        wait_idle();
        scan(8, 32'hCAFE_F00D, 0, 1'b1, fk);
        check("sof_fin_k", 32'(fk), 32'd6);
        wait_idle();
        scan(0, 32'hCAFE_F00D, 0, 1'b0, fk);
        check("zero_fin_k", 32'(fk <= 1), 32'd1);
        @(negedge CLK);
        check("zero_fin", 32'(fin0), 32'd1);
        check("zero_busy", 32'(busy0), 32'd0);
        // abort while a match is pending
        match_ready = 1'b0;
        hash_count  = 10'd8;
        cmp_data    = 32'hCAFE_F00D;
        start       = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 20 && !mv0; i++) @(negedge CLK);
        check("abort_pre_mv", 32'(mv0), 32'd1);
        check("abort_pre_found", 32'(found0), 32'd1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_mv", 32'(mv0), 32'd0);
        check("abort_found", 32'(found0), 32'd0);
        check("abort_fin", 32'(fin0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        // start together with abort
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", 32'(busy0), 32'd0);
        check("startabort_fin", 32'(fin0), 32'd0);
        // asynchronous reset mid-scan
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 20 && !mv0; i++) @(negedge CLK);
        check("rstmid_pre_mv", 32'(mv0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy0), 32'd0);
        check("rstmid_mv", 32'(mv0), 32'd0);
        check("rstmid_num", 32'(num0), 32'd0);
        check("rstmid_found", 32'(found0), 32'd0);
        check("rstmid_fin", 32'(fin0), 32'd0);
        @(negedge CLK);
        rst_n       = 1'b1;
        match_ready = 1'b1;
        @(negedge CLK);
        // full depth, hash_count beyond depth, match on the last entry with back-pressure
        for (int i = 0; i < NH; i++) write_entry(i, 32'h1000_0000 + 32'(i));
        scan(NH + 5, 32'h1000_01FF, 3, 1'b0, fk);
        check("full_fin_k", 32'(fk), 32'd517);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
